// File: rtl/rv_pkg.sv
// Shared RV32 core definitions used by the EX-stage multiply/divide unit.
package rv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [6:0]  OPC_OP    = 7'b0110011;
    localparam logic [6:0]  F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned multiply/divide datapath: shift-add for mul,
// restoring trial subtract for div. Pure combinational.
module muldiv_step #(
    parameter int unsigned XLEN = rv_pkg::XLEN
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] mcand_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shl;
    logic [XLEN:0] diff;

    always_comb begin
        sum   = {1'b0, acc_i} + {1'b0, mcand_i};
        shl   = {acc_i, lo_i[XLEN-1]};
        diff  = shl - {1'b0, mcand_i};
        acc_o = acc_i;
        lo_o  = lo_i;
        if (is_div_i) begin
            // Partial remainder is always below 2*divisor, so diff's top bit is the borrow.
            if (!diff[XLEN]) begin
                acc_o = diff[XLEN-1:0];
                lo_o  = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = shl[XLEN-1:0];
                lo_o  = {lo_i[XLEN-2:0], 1'b0};
            end
        end else if (lo_i[0]) begin
            {acc_o, lo_o} = {sum, lo_i[XLEN-1:1]};
        end else begin
            {acc_o, lo_o} = {1'b0, acc_i, lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/exe_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU. Stalls the
// pipeline while iterating one bit per cycle; squashed by a branch/jump flush.
module exe_muldiv_seq
    import rv_pkg::*;
#(
    parameter int unsigned XLEN         = rv_pkg::XLEN,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned     CntW   = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN - 1){1'b0}}};

    muldiv_state_e   state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    muldiv_op_e      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic            neg_q, neg_d;
    logic            spec_q, spec_d;
    logic [XLEN-1:0] spec_res_q, spec_res_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode for the incoming instruction
    muldiv_op_e      op_in;
    logic            a_signed, b_signed, sign_a, sign_b;
    logic            div_zero, ovf, special, neg_in;
    logic [XLEN-1:0] mag_a, mag_b, spec_res_in;

    always_comb begin
        op_in       = muldiv_op_e'(funct3_i);
        a_signed    = (op_in == OpMulh) || (op_in == OpMulhsu) ||
                      (op_in == OpDiv) || (op_in == OpRem);
        b_signed    = (op_in == OpMulh) || (op_in == OpDiv) || (op_in == OpRem);
        sign_a      = a_signed & op_a_i[XLEN-1];
        sign_b      = b_signed & op_b_i[XLEN-1];
        mag_a       = sign_a ? -op_a_i : op_a_i;
        mag_b       = sign_b ? -op_b_i : op_b_i;
        div_zero    = funct3_i[2] && (op_b_i == '0);
        ovf         = ((op_in == OpDiv) || (op_in == OpRem)) &&
                      (op_a_i == MinInt) && (op_b_i == '1);
        special     = div_zero || ovf;
        // Remainder takes the dividend's sign; everything else takes sign(a)^sign(b).
        neg_in      = (op_in == OpRem) ? sign_a : (sign_a ^ sign_b);
        spec_res_in = '0;
        if (div_zero) begin
            spec_res_in = funct3_i[1] ? op_a_i : '1;
        end else if (ovf) begin
            spec_res_in = funct3_i[1] ? '0 : MinInt;
        end
    end

    logic [XLEN-1:0] step_acc, step_lo;

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div_i(op_q[2]),
        .acc_i   (acc_q),
        .lo_i    (lo_q),
        .mcand_i (mcand_q),
        .acc_o   (step_acc),
        .lo_o    (step_lo)
    );

    // Sign fix-up of the finished magnitude result
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

    always_comb begin
        prod     = {acc_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        quot_fix = neg_q ? -lo_q : lo_q;
        rem_fix  = neg_q ? -acc_q : acc_q;
        unique case (op_q)
            OpMul:                     final_res = prod_fix[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: final_res = prod_fix[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             final_res = quot_fix;
            default:                   final_res = rem_fix;
        endcase
        if (spec_q) begin
            final_res = spec_res_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        op_d           = op_q;
        acc_d          = acc_q;
        lo_d           = lo_q;
        mcand_d        = mcand_q;
        neg_d          = neg_q;
        spec_d         = spec_q;
        spec_res_d     = spec_res_q;
        result_d       = result_q;
        stall_req_o    = 1'b0;
        result_valid_o = 1'b0;
        result_o       = result_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !flush_i) begin
                    stall_req_o = 1'b1;
                    op_d        = op_in;
                    acc_d       = '0;
                    lo_d        = mag_a;
                    mcand_d     = mag_b;
                    neg_d       = neg_in;
                    spec_d      = special;
                    spec_res_d  = spec_res_in;
                    if (FAST_SPECIAL && special) begin
                        state_d = StDone;
                        count_d = '0;
                    end else begin
                        state_d = StBusy;
                        count_d = CntW'(XLEN);
                    end
                end
            end
            StBusy: begin
                stall_req_o = 1'b1;
                if (flush_i) begin
                    state_d = StIdle;
                    count_d = '0;
                end else begin
                    acc_d   = step_acc;
                    lo_d    = step_lo;
                    count_d = count_q - CntW'(1);
                    if (count_q == CntW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!flush_i) begin
                    result_valid_o = 1'b1;
                    result_o       = final_res;
                    result_d       = final_res;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy_o = (state_q != StIdle);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            count_q    <= '0;
            op_q       <= OpMul;
            acc_q      <= '0;
            lo_q       <= '0;
            mcand_q    <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            mcand_q    <= mcand_d;
            neg_q      <= neg_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Self-checking bench for exe_muldiv_seq: directed RV32M corner cases plus random
// operations against an arithmetic reference model.
module tb_exe_muldiv_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        flush_i;
    logic        stall_req_o;
    logic        busy_o;
    logic        result_valid_o;
    logic [31:0] result_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_res;

    exe_muldiv_seq dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .funct3_i      (funct3_i),
        .op_a_i        (op_a_i),
        .op_b_i        (op_b_i),
        .flush_i       (flush_i),
        .stall_req_o   (stall_req_o),
        .busy_o        (busy_o),
        .result_valid_o(result_valid_o),
        .result_o      (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'h0, b};
        ia = a;
        ib = b;
        case (f3)
            3'd0: p = sa * sb;
            3'd1: p = sa * sb;
            3'd2: p = sa * ub;
            3'd3: p = {32'h0, a} * ub;
            default: p = '0;
        endcase
        case (f3)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        bit fast;
        fast = f3[2] && ((b == 0) ||
               (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return fast ? 1 : 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            4: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, wait for result_valid (bounded), check latency, stall length and value.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b);
        int lat, stall_cnt, exp_lat;
        bit got;
        logic [31:0] res, exp;
        exp     = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        @(negedge clk_i);
        start_i  = 1'b1;
        funct3_i = f3;
        op_a_i   = a;
        op_b_i   = b;
        #1;
        stall_cnt = stall_req_o ? 1 : 0;
        lat = 0;
        got = 1'b0;
        res = '0;
        while (!got && lat < 50) begin
            @(negedge clk_i);
            lat++;
            if (stall_req_o) stall_cnt++;
            if (result_valid_o) begin
                got     = 1'b1;
                res     = result_o;
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        check_eq({tag, "_done"}, 32'(got), 32'd1);
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_stall"}, stall_cnt, exp_lat);
        check_eq({tag, "_res"}, res, exp);
        @(negedge clk_i);
        check_eq({tag, "_hold"}, result_o, exp);
        check_eq({tag, "_idle"}, {30'h0, busy_o, result_valid_o}, 32'h0);
        last_res = exp;
    endtask

    initial begin
        int valid_seen;
        rst_ni   = 1'b0;
        start_i  = 1'b0;
        flush_i  = 1'b0;
        funct3_i = 3'd0;
        op_a_i   = '0;
        op_b_i   = '0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_outs", {29'h0, busy_o, stall_req_o, result_valid_o}, 32'h0);
        check_eq("rst_res", result_o, 32'h0);
        rst_ni = 1'b1;

        run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
        run_op("div_5_0", 3'd4, 32'd5, 32'd0);
        run_op("rem_5_0", 3'd6, 32'd5, 32'd0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush in the middle of an iteration
        @(negedge clk_i);
        start_i  = 1'b1;
        funct3_i = 3'd0;
        op_a_i   = 32'd123;
        op_b_i   = 32'd456;
        repeat (10) @(negedge clk_i);
        start_i = 1'b0;
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check_eq("flush_outs", {29'h0, busy_o, stall_req_o, result_valid_o}, 32'h0);
        valid_seen = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (result_valid_o) valid_seen++;
        end
        check_eq("flush_novalid", valid_seen, 0);
        check_eq("flush_res_kept", result_o, last_res);
        run_op("after_flush", 3'd5, 32'd1000, 32'd33);

        // Reset mid-operation
        @(negedge clk_i);
        start_i  = 1'b1;
        funct3_i = 3'd4;
        op_a_i   = 32'd999;
        op_b_i   = 32'd3;
        repeat (5) @(negedge clk_i);
        start_i = 1'b0;
        rst_ni  = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        check_eq("midrst_outs", {29'h0, busy_o, stall_req_o, result_valid_o}, 32'h0);
        check_eq("midrst_res", result_o, 32'h0);

        // start and flush together in IDLE
        @(negedge clk_i);
        start_i = 1'b1;
        flush_i = 1'b1;
        #1;
        check_eq("sf_stall", {31'h0, stall_req_o}, 32'h0);
        @(negedge clk_i);
        start_i = 1'b0;
        flush_i = 1'b0;
        check_eq("sf_idle", {31'h0, busy_o}, 32'h0);

        for (int i = 0; i < 60; i++) begin
            run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick_operand(),
                   pick_operand());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
